// File: rtl/task1rom_if.sv
// Read port bundle for the constant lookup ROM.
// The master drives the word address and receives the registered read word.
interface task1rom_if;
  logic [9:0] address;
  logic [9:0] read_data;

  modport master (output address, input  read_data);
  modport slave  (input  address, output read_data);
endinterface

// File: rtl/task1rom.sv
// Fixed 1024 x 10-bit lookup ROM with a one-cycle registered read.
// Only the first three words are non-zero. The table is pure decode logic,
// so it carries no reset. Only the output register is cleared by rst.
module task1rom (
  input  logic       clk,
  input  logic       rst,
  task1rom_if.slave  bus
);

  logic [9:0] read_data_d;
  logic [9:0] read_data_q;

  // Table lookup: every address is decoded, and unlisted words read as zero
  always_comb begin
    read_data_d = 10'b0000000000;
    case (bus.address)
      10'd0:   read_data_d = 10'b0000000001;
      10'd1:   read_data_d = 10'b0011110001;
      10'd2:   read_data_d = 10'b1010101010;
      default: read_data_d = 10'b0000000000;
    endcase
  end

  // Output register: reset forces zero at once and takes priority over the clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) read_data_q <= 10'b0000000000;
    else     read_data_q <= read_data_d;
  end

  assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_task1rom.sv
// Self-checking bench for task1rom. Inputs change on the falling edge,
// and outputs are sampled 1 ns after the rising edge.
module tb_task1rom;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  task1rom_if bif ();

  task1rom dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference content table, taken directly from the listed word values
  function automatic logic [9:0] ref_word(input int addr);
    if (addr == 0)      return 10'd1;
    else if (addr == 1) return 10'd241;
    else if (addr == 2) return 10'd682;
    else                return 10'd0;
  endfunction

  task automatic drive(input int addr);
    @(negedge clk);
    bif.address = addr[9:0];
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.address = 10'd2;
    #2;
    checks++;
    if (bif.read_data !== 10'd0) begin
      errors++;
      $display("FAIL reset_async got %b want %b", bif.read_data, 10'd0);
    end
    for (int i = 0; i < 2; i++) begin
      edge_sample();
      checks++;
      if (bif.read_data !== 10'd0) begin
        errors++;
        $display("FAIL reset_hold got %b want %b", bif.read_data, 10'd0);
      end
    end
  endtask

  task automatic test_sequential();
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 3; a++) begin
      if (a != 0) drive(a);
      else bif.address = 10'd0;
      edge_sample();
      checks++;
      if (bif.read_data !== ref_word(a)) begin
        errors++;
        $display("FAIL seq_read addr %0d got %b want %b", a, bif.read_data, ref_word(a));
      end
    end
  endtask

  task automatic test_unprogrammed();
    int addrs[3] = '{3, 512, 1023};
    foreach (addrs[k]) begin
      drive(2);
      edge_sample();
      drive(addrs[k]);
      edge_sample();
      checks++;
      if (bif.read_data !== 10'd0) begin
        errors++;
        $display("FAIL unprog addr %0d got %b want %b", addrs[k], bif.read_data, 10'd0);
      end
    end
  endtask

  task automatic test_hold();
    drive(1);
    edge_sample();
    #1;
    bif.address = 10'd2;
    #2;
    checks++;
    if (bif.read_data !== 10'b0011110001) begin
      errors++;
      $display("FAIL hold_between_edges got %b want %b", bif.read_data, 10'b0011110001);
    end
    edge_sample();
    checks++;
    if (bif.read_data !== 10'b1010101010) begin
      errors++;
      $display("FAIL hold_next_edge got %b want %b", bif.read_data, 10'b1010101010);
    end
  endtask

  task automatic test_async_reset();
    drive(2);
    edge_sample();
    checks++;
    if (bif.read_data !== 10'b1010101010) begin
      errors++;
      $display("FAIL pre_reset got %b want %b", bif.read_data, 10'b1010101010);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bif.read_data !== 10'd0) begin
      errors++;
      $display("FAIL midstream_async got %b want %b", bif.read_data, 10'd0);
    end
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      checks++;
      if (bif.read_data !== 10'd0) begin
        errors++;
        $display("FAIL reset_edges %0d got %b want %b", i, bif.read_data, 10'd0);
      end
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    rst = 1'b0;
    bif.address = 10'd1;
    edge_sample();
    checks++;
    if (bif.read_data !== 10'b0011110001) begin
      errors++;
      $display("FAIL release_first got %b want %b", bif.read_data, 10'b0011110001);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    for (int a = 0; a < 1024; a++) begin
      drive(a);
      edge_sample();
      checks++;
      if (bif.read_data !== ref_word(a)) begin
        errors++;
        bad++;
        if (bad <= 8)
          $display("FAIL sweep addr %0d got %b want %b", a, bif.read_data, ref_word(a));
      end
    end
  endtask

  // Random addresses with occasional reset pulses.
  // Reads that land in the low programmed words are made more frequent.
  task automatic test_random();
    logic [9:0] exp;
    int a;
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1023));
      bif.address = a[9:0];
      rst = ($urandom_range(0, 19) == 0);
      exp = rst ? 10'd0 : ref_word(a);
      edge_sample();
      checks++;
      if (bif.read_data !== exp) begin
        errors++;
        bad++;
        if (bad <= 8)
          $display("FAIL random addr %0d rst %0b got %b want %b", a, rst, bif.read_data, exp);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bif.address = 10'd0;
    test_reset();
    test_sequential();
    test_unprogrammed();
    test_hold();
    test_async_reset();
    test_release();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
